// File: rtl/task_mailbox_axil_slave.sv
// AXI4-Lite mailbox responder: input/output vector buffers plus the handshake
// registers that sequence one task-engine run at a time.
module task_mailbox_axil_slave #(
  parameter int unsigned ADDR_WIDTH    = 17,
  parameter int unsigned BUF_DEPTH     = 512,
  parameter logic [31:0] ENABLED_MASK  = 32'h0000_7FFF,
  parameter int unsigned TASK_ID_WIDTH = 5,
  localparam int unsigned BUF_AW       = $clog2(BUF_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic                     task_start,
  output logic [TASK_ID_WIDTH-1:0] task_id,
  input  logic [BUF_AW-1:0]        in_rd_addr,
  output logic [31:0]              in_rd_data,
  input  logic                     out_wr_en,
  input  logic [BUF_AW-1:0]        out_wr_addr,
  input  logic [31:0]              out_wr_data,
  input  logic                     task_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  typedef enum logic [1:0] {RG_IN, RG_OUT, RG_CSR, RG_NONE} region_t;

  localparam logic [31:0] IN_END   = 32'(BUF_DEPTH * 4);
  localparam logic [31:0] OUT_END  = 32'(BUF_DEPTH * 8);
  localparam logic [31:0] CSR_BASE = 32'h0001_0000;
  localparam logic [31:0] CSR_END  = 32'h0001_0014;

  localparam logic [2:0] CSR_PL_READY = 3'd0;
  localparam logic [2:0] CSR_ENABLED  = 3'd1;
  localparam logic [2:0] CSR_CURRENT  = 3'd2;
  localparam logic [2:0] CSR_TV_IN    = 3'd3;
  localparam logic [2:0] CSR_TV_OUT   = 3'd4;

  function automatic region_t f_region(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] v;
    v = 32'(a);
    if (v < IN_END)                        return RG_IN;
    else if (v < OUT_END)                  return RG_OUT;
    else if (v >= CSR_BASE && v < CSR_END) return RG_CSR;
    else                                   return RG_NONE;
  endfunction

  logic                     r_live;
  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_task_start;
  logic [TASK_ID_WIDTH-1:0] r_cur_task;

  logic                  r_aw_have;
  logic                  r_w_have;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_wr_exec;
  logic                  w_wr_err;
  logic                  w_in_we;
  logic                  w_cur_we;
  logic                  w_start_req;
  logic                  w_stop_req;
  logic                  w_task_ok;
  logic [31:0]           w_cur_ext;
  logic [BUF_AW-1:0]     w_wr_word;

  logic                  r_rd_pend;
  logic                  r_rd_stage;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [31:0]           r_rdata;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  w_ar_hs;
  logic [31:0]           w_rd_value;
  logic                  w_rd_err;
  logic [BUF_AW-1:0]     w_ar_word;

  logic [31:0] r_in_mem  [BUF_DEPTH];
  logic [31:0] r_out_mem [BUF_DEPTH];
  logic [31:0] r_in_psq;
  logic [31:0] r_out_psq;
  logic [31:0] r_in_rd_data;

  assign s_axi_awready = r_live & ~r_aw_have & ~r_bvalid;
  assign s_axi_wready  = r_live & ~r_w_have & ~r_bvalid;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_live & ~r_rd_pend;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign task_start    = r_task_start;
  assign task_id       = r_cur_task;
  assign in_rd_data    = r_in_rd_data;

  assign w_aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_w_hs    = s_axi_wvalid & s_axi_wready;
  assign w_ar_hs   = s_axi_arvalid & s_axi_arready;
  assign w_wr_exec = r_aw_have & r_w_have & ~r_bvalid;
  assign w_wr_word = r_awaddr[BUF_AW+1:2];
  assign w_ar_word = s_axi_araddr[BUF_AW+1:2];

  assign w_cur_ext = 32'(r_cur_task);
  assign w_task_ok = (w_cur_ext != '0) && (w_cur_ext <= 32'd32) &&
                     ENABLED_MASK[5'(w_cur_ext - 32'd1)];

  always_ff @(posedge clk) begin
    if (rst) r_live <= 1'b0;
    else     r_live <= 1'b1;
  end

  // Write side: AW and W are latched independently, then executed together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_have <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_have <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_wr_exec) begin
        r_aw_have <= 1'b0;
        r_w_have  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_err ? 2'b10 : 2'b00;
      end
      if (r_bvalid && s_axi_bready) r_bvalid <= 1'b0;
    end
  end

  always_comb begin
    w_wr_err    = 1'b0;
    w_in_we     = 1'b0;
    w_cur_we    = 1'b0;
    w_start_req = 1'b0;
    w_stop_req  = 1'b0;
    if (w_wr_exec) begin
      case (f_region(r_awaddr))
        RG_IN: begin
          if (r_state == ST_BUSY) w_wr_err = 1'b1;
          else                    w_in_we  = 1'b1;
        end
        RG_OUT: w_wr_err = 1'b1;
        RG_CSR: begin
          if (r_wstrb[0]) begin
            case (r_awaddr[4:2])
              CSR_CURRENT: w_cur_we = (r_state != ST_BUSY);
              CSR_TV_IN: begin
                if (!r_wdata[0])             w_stop_req  = 1'b1;
                else if (r_state != ST_BUSY) begin
                  if (w_task_ok) w_start_req = 1'b1;
                  else           w_wr_err    = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        default: w_wr_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_cur_task <= '0;
    else if (w_cur_we) r_cur_task <= r_wdata[TASK_ID_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_task_start <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_task_start <= w_start_req;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_req) w_state_next = ST_BUSY;
      ST_BUSY: if (task_done)   w_state_next = ST_DONE;
      ST_DONE: begin
        if (w_start_req)     w_state_next = ST_BUSY;
        else if (w_stop_req) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Read side: buffers are sampled on the AR handshake, rdata registered one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_stage <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= 2'b00;
      r_rdata    <= '0;
      r_araddr   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rd_pend  <= 1'b1;
        r_rd_stage <= 1'b1;
        r_araddr   <= s_axi_araddr;
      end
      if (r_rd_stage) begin
        r_rd_stage <= 1'b0;
        r_rvalid   <= 1'b1;
        r_rdata    <= w_rd_value;
        r_rresp    <= w_rd_err ? 2'b10 : 2'b00;
      end
      if (r_rvalid && s_axi_rready) begin
        r_rvalid  <= 1'b0;
        r_rd_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd_value = '0;
    w_rd_err   = 1'b0;
    case (f_region(r_araddr))
      RG_IN:  w_rd_value = r_in_psq;
      RG_OUT: w_rd_value = r_out_psq;
      RG_CSR: begin
        case (r_araddr[4:2])
          CSR_PL_READY: w_rd_value = {31'b0, r_state == ST_IDLE};
          CSR_ENABLED:  w_rd_value = ENABLED_MASK;
          CSR_CURRENT:  w_rd_value = 32'(r_cur_task);
          CSR_TV_IN:    w_rd_value = {31'b0, r_state == ST_BUSY};
          CSR_TV_OUT:   w_rd_value = {31'b0, r_state == ST_DONE};
          default:      w_rd_value = '0;
        endcase
      end
      default: w_rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (w_in_we && r_wstrb[b]) r_in_mem[w_wr_word][8*b +: 8] <= r_wdata[8*b +: 8];
    end
    if (w_ar_hs) r_in_psq <= r_in_mem[w_ar_word];
    r_in_rd_data <= r_in_mem[in_rd_addr];
  end

  // Engine write and PS read share an edge; the PS read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (out_wr_en) r_out_mem[out_wr_addr] <= out_wr_data;
    if (w_ar_hs)   r_out_psq <= r_out_mem[w_ar_word];
  end

endmodule
